// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU between two requesters
module alu_share_arbiter #(
    parameter int unsigned MUL_WAIT = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Req0_Valid,
    input  logic [31:0] Req0_Src1,
    input  logic [31:0] Req0_Src2,
    input  logic [2:0]  Req0_Op,
    output logic        Req0_Ready,
    input  logic        Req1_Valid,
    input  logic [31:0] Req1_Src1,
    input  logic [31:0] Req1_Src2,
    input  logic [2:0]  Req1_Op,
    output logic        Req1_Ready,
    output logic        Rsp0_Valid,
    output logic        Rsp1_Valid,
    output logic [31:0] Rsp_Result,
    output logic        Rsp_Zero,
    output logic [31:0] Alu_Src1,
    output logic [31:0] Alu_Src2,
    output logic [2:0]  Alu_Control,
    input  logic [31:0] Alu_Result,
    input  logic        Alu_Zero,
    output logic        Busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [2:0] OP_MUL = 3'b101;

    logic [1:0]  state_q, state_d;
    logic        ptr_q, owner_q;
    logic [3:0]  cnt_q;
    logic [31:0] src1_q, src2_q, res_q;
    logic [2:0]  op_q;
    logic        zero_q, rsp0_q, rsp1_q;
    logic        idle, accept, grant;
    logic [2:0]  op_sel;

    // Grant the only valid requester, or the pointer's choice when both are valid
    always_comb begin
        idle       = (state_q == IDLE);
        grant      = (Req0_Valid && Req1_Valid) ? ptr_q : Req1_Valid;
        accept     = idle && (Req0_Valid || Req1_Valid);
        Req0_Ready = idle && Req0_Valid && !grant;
        Req1_Ready = idle && Req1_Valid && grant;
        op_sel     = grant ? Req1_Op : Req0_Op;
        state_d    = (state_q == IDLE) ? (accept ? EXEC : IDLE) :
                     (state_q == EXEC) ? ((cnt_q == 4'd0) ? RESP : EXEC) : IDLE;
    end

    // Operation capture, multiply wait countdown, result capture and pointer update
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            cnt_q   <= 4'd0;
            src1_q  <= 32'd0;
            src2_q  <= 32'd0;
            op_q    <= 3'b000;
            res_q   <= 32'd0;
            zero_q  <= 1'b0;
            rsp0_q  <= 1'b0;
            rsp1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rsp0_q  <= 1'b0;
            rsp1_q  <= 1'b0;
            if (accept) begin
                src1_q  <= grant ? Req1_Src1 : Req0_Src1;
                src2_q  <= grant ? Req1_Src2 : Req0_Src2;
                op_q    <= op_sel;
                owner_q <= grant;
                cnt_q   <= (op_sel == OP_MUL) ? 4'(MUL_WAIT) : 4'd0;
            end
            if (state_q == EXEC && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
            if (state_q == EXEC && cnt_q == 4'd0) begin
                res_q  <= Alu_Result;
                zero_q <= Alu_Zero;
                rsp0_q <= !owner_q;
                rsp1_q <= owner_q;
            end
            if (state_q == RESP) ptr_q <= !owner_q;
        end
    end

    assign Alu_Src1    = src1_q;
    assign Alu_Src2    = src2_q;
    assign Alu_Control = op_q;
    assign Rsp_Result  = res_q;
    assign Rsp_Zero    = zero_q;
    assign Rsp0_Valid  = rsp0_q;
    assign Rsp1_Valid  = rsp1_q;
    assign Busy        = !idle;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed table and sequence checks with a behavioural ALU
module tb_alu_share_arbiter;
    logic        CLK, RST;
    logic        Req0_Valid, Req1_Valid, Req0_Ready, Req1_Ready;
    logic [31:0] Req0_Src1, Req0_Src2, Req1_Src1, Req1_Src2;
    logic [2:0]  Req0_Op, Req1_Op;
    logic        Rsp0_Valid, Rsp1_Valid, Rsp_Zero, Busy, Alu_Zero;
    logic [31:0] Rsp_Result, Alu_Src1, Alu_Src2, Alu_Result;
    logic [2:0]  Alu_Control;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        port;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] res;
        logic        zero;
        int          lat;
    } vec_t;
    vec_t tbl [9];

    alu_share_arbiter #(.MUL_WAIT(2)) dut (
        .CLK(CLK), .RST(RST),
        .Req0_Valid(Req0_Valid), .Req0_Src1(Req0_Src1), .Req0_Src2(Req0_Src2), .Req0_Op(Req0_Op), .Req0_Ready(Req0_Ready),
        .Req1_Valid(Req1_Valid), .Req1_Src1(Req1_Src1), .Req1_Src2(Req1_Src2), .Req1_Op(Req1_Op), .Req1_Ready(Req1_Ready),
        .Rsp0_Valid(Rsp0_Valid), .Rsp1_Valid(Rsp1_Valid), .Rsp_Result(Rsp_Result), .Rsp_Zero(Rsp_Zero),
        .Alu_Src1(Alu_Src1), .Alu_Src2(Alu_Src2), .Alu_Control(Alu_Control),
        .Alu_Result(Alu_Result), .Alu_Zero(Alu_Zero), .Busy(Busy)
    );

    // Behavioural ALU: 000 add, 001 sub, 010 and, 100 or, 101 mul, 110 unsigned slt, others 0
    always_comb begin
        Alu_Result = 32'd0;
        case (Alu_Control)
            3'b000: Alu_Result = Alu_Src1 + Alu_Src2;
            3'b001: Alu_Result = Alu_Src1 - Alu_Src2;
            3'b010: Alu_Result = Alu_Src1 & Alu_Src2;
            3'b100: Alu_Result = Alu_Src1 | Alu_Src2;
            3'b101: Alu_Result = Alu_Src1 * Alu_Src2;
            3'b110: Alu_Result = {31'd0, Alu_Src1 < Alu_Src2};
            default: Alu_Result = 32'd0;
        endcase
        Alu_Zero = (Alu_Result == 32'd0);
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic txn(input vec_t v);
        int lat;
        int busy_cnt;
        if (v.port) {Req1_Valid, Req1_Src1, Req1_Src2, Req1_Op} = {1'b1, v.a, v.b, v.op};
        else        {Req0_Valid, Req0_Src1, Req0_Src2, Req0_Op} = {1'b1, v.a, v.b, v.op};
        #1;
        chk("ready", {30'd0, Req1_Ready, Req0_Ready}, v.port ? 32'd2 : 32'd1);
        @(posedge CLK);
        #1;
        Req0_Valid = 1'b0;
        Req1_Valid = 1'b0;
        lat = 0;
        busy_cnt = 0;
        do begin
            @(negedge CLK);
            lat++;
            busy_cnt += int'(Busy);
        end while (!(Rsp0_Valid || Rsp1_Valid) && lat < 30);
        chk("latency", lat, v.lat);
        chk("rsp_port", {30'd0, Rsp1_Valid, Rsp0_Valid}, v.port ? 32'd2 : 32'd1);
        chk("result", Rsp_Result, v.res);
        chk("zero", {31'd0, Rsp_Zero}, {31'd0, v.zero});
        chk("busy_cycles", busy_cnt, v.lat);
        @(negedge CLK);
        chk("after_rsp", {29'd0, Rsp1_Valid, Rsp0_Valid, Busy}, 32'd0);
        chk("hold_result", Rsp_Result, v.res);
    endtask

    initial begin
        tbl[0] = '{1'b0, 32'd5,        32'd7,        3'b000, 32'd12,         1'b0, 2};
        tbl[1] = '{1'b1, 32'hF0,       32'h0F,       3'b100, 32'hFF,         1'b0, 2};
        tbl[2] = '{1'b1, 32'h10000,    32'h10000,    3'b101, 32'd0,          1'b1, 4};
        tbl[3] = '{1'b0, 32'h1234,     32'h55,       3'b111, 32'd0,          1'b1, 2};
        tbl[4] = '{1'b0, 32'd3,        32'hFFFFFFFF, 3'b110, 32'd1,          1'b0, 2};
        tbl[5] = '{1'b0, 32'd6,        32'd7,        3'b101, 32'd42,         1'b0, 4};
        tbl[6] = '{1'b1, 32'hF0F0,     32'h0FF0,     3'b010, 32'h00F0,       1'b0, 2};
        tbl[7] = '{1'b1, 32'd9,        32'd4,        3'b011, 32'd0,          1'b1, 2};
        tbl[8] = '{1'b0, 32'd5,        32'd7,        3'b001, 32'hFFFFFFFE,   1'b0, 2};
        {Req0_Valid, Req1_Valid} = 2'b00;
        {Req0_Src1, Req0_Src2, Req1_Src1, Req1_Src2} = '0;
        {Req0_Op, Req1_Op} = '0;
        RST = 1'b1;
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("reset_ctrl", {27'd0, Req0_Ready, Req1_Ready, Rsp0_Valid, Rsp1_Valid, Busy}, 32'd0);
        chk("reset_alu", {Alu_Src1 | Alu_Src2 | Rsp_Result}, 32'd0);
        chk("reset_op_zero", {28'd0, Alu_Control, Rsp_Zero}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        // both valid after reset: requester 0 first, requester 1 three cycles later
        {Req0_Valid, Req0_Src1, Req0_Src2, Req0_Op} = {1'b1, 32'd9, 32'd9, 3'b001};
        {Req1_Valid, Req1_Src1, Req1_Src2, Req1_Op} = {1'b1, 32'hF0, 32'h0F, 3'b100};
        #1;
        chk("both_first_grant", {30'd0, Req1_Ready, Req0_Ready}, 32'd1);
        @(posedge CLK);
        #1 Req0_Valid = 1'b0;
        @(negedge CLK);
        chk("exec_no_ready", {30'd0, Req1_Ready, Req0_Ready}, 32'd0);
        @(negedge CLK);
        chk("sub_rsp", {30'd0, Rsp1_Valid, Rsp0_Valid}, 32'd1);
        chk("sub_result", Rsp_Result, 32'd0);
        chk("sub_zero", {31'd0, Rsp_Zero}, 32'd1);
        @(negedge CLK);
        chk("second_grant", {30'd0, Req1_Ready, Req0_Ready}, 32'd2);
        @(posedge CLK);
        #1 Req1_Valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("or_rsp", {30'd0, Rsp1_Valid, Rsp0_Valid}, 32'd2);
        chk("or_result", Rsp_Result, 32'hFF);
        chk("or_zero", {31'd0, Rsp_Zero}, 32'd0);
        // both held valid: six alternating operations, one response per three cycles
        @(negedge CLK);
        {Req0_Valid, Req0_Src1, Req0_Src2, Req0_Op} = {1'b1, 32'd1, 32'd2, 3'b000};
        {Req1_Valid, Req1_Src1, Req1_Src2, Req1_Op} = {1'b1, 32'd10, 32'd4, 3'b001};
        for (int i = 0; i < 18; i++) begin
            logic [1:0] oh;
            if (i > 0) @(negedge CLK);
            #1;
            oh = ((i / 3) % 2 == 1) ? 2'b10 : 2'b01;
            chk($sformatf("rr_cycle%0d", i), {28'd0, Req1_Ready, Req0_Ready, Rsp1_Valid, Rsp0_Valid},
                {28'd0, (i % 3 == 0) ? oh : 2'b00, (i % 3 == 2) ? oh : 2'b00});
            if (i % 3 == 2) chk($sformatf("rr_result%0d", i / 3), Rsp_Result, oh[1] ? 32'd6 : 32'd3);
        end
        Req0_Valid = 1'b0;
        Req1_Valid = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < 9; i++) begin
            txn(tbl[i]);
        end
        // reset during the EXEC phase of a multiply
        Req1_Valid = 1'b1; Req1_Src1 = 32'd3; Req1_Src2 = 32'd4; Req1_Op = 3'b101;
        #1;
        chk("mul_abort_grant", {30'd0, Req1_Ready, Req0_Ready}, 32'd2);
        @(posedge CLK);
        #1 Req1_Valid = 1'b0;
        @(negedge CLK);
        chk("mul_abort_busy", {31'd0, Busy}, 32'd1);
        RST = 1'b0;
        #1;
        chk("abort_ctrl", {29'd0, Rsp0_Valid, Rsp1_Valid, Busy}, 32'd0);
        chk("abort_alu", {Alu_Src1 | Alu_Src2 | Rsp_Result}, 32'd0);
        chk("abort_op", {29'd0, Alu_Control}, 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        Req0_Valid = 1'b1;
        Req1_Valid = 1'b1;
        #1;
        chk("post_reset_ptr", {30'd0, Req1_Ready, Req0_Ready}, 32'd1);
        Req0_Valid = 1'b0;
        #1;
        chk("post_reset_r1_alone", {30'd0, Req1_Ready, Req0_Ready}, 32'd2);
        Req1_Valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk($sformatf("no_pulse%0d", i), {29'd0, Rsp1_Valid, Rsp0_Valid, Busy}, 32'd0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
